seg_scan_driver: RTL

- Parametrised, time-multiplexed 7-segment scan driver for the EGO1 display; successor to the piano's static single-value segment decoder.
- Drives NUM_DIGITS digit enables one at a time, with per-digit glyph codes, a decimal-point mask, an enable mask and a blink mask.
- A load strobe double-buffers the display contents.
- Sits between the piano/learn-mode controller (which supplies digit, interval and octave codes) and the board segment pins.

---
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan driver.
//
// It scans NUM_DIGITS digits one at a time. Each digit slot lasts SCAN_DIV
// clocks and opens with BLANK_CYC clocks where every enable is low, so the
// previous digit's segments do not ghost onto the next one. The display
// contents sit in shadow registers that are loaded by load_i. Blinking uses
// a phase flag that toggles every BLINK_DIV scan ticks.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   load_i       copy codes/dp/enable/blink masks into the shadow registers
//   codes_i      glyph code per digit; digit i is at [4i+3:4i]
//   dp_mask_i    decimal point per digit
//   digit_en_i   1 = digit displayed
//   blink_en_i   global blink enable; used live, not shadowed
//   blink_mask_i 1 = digit blinks while blink_en_i is high
//   seg_out_o    segments a..g at [7:1], dp at [0]; active high, registered
//   seg_en_o     one-hot digit enable; active high, registered
//   scan_idx_o   index of the digit that currently owns the slot
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter int unsigned BLINK_DIV  = 250,
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] codes_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    blink_en_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [7:0]              seg_out_o,
  output logic [NUM_DIGITS-1:0]   seg_en_o,
  output logic [IdxW-1:0]         scan_idx_o
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PreW-1:0] PreLast  = PreW'(SCAN_DIV - 1);
  localparam logic [PreW-1:0] BlankCyc = PreW'(BLANK_CYC);
  localparam logic [BlkW-1:0] BlkLast  = BlkW'(BLINK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  // Segment pattern for a glyph code; bit 0 (dp) is always 0 here.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = 8'hFC;
      4'h1:    seg = 8'h60;
      4'h2:    seg = 8'hDA;
      4'h3:    seg = 8'hF2;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'hB6;
      4'h6:    seg = 8'hBE;
      4'h7:    seg = 8'hE0;
      4'h8:    seg = 8'hFE;
      4'h9:    seg = 8'hE6;
      4'hA:    seg = 8'h1C;  // L
      4'hB:    seg = 8'hAA;  // M
      4'hC:    seg = 8'h6E;  // H
      4'hD:    seg = 8'h02;  // -
      default: seg = 8'h00;  // E/F: blank
    endcase
    return seg;
  endfunction

  logic [PreW-1:0]                pre_q, pre_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [BlkW-1:0]                blk_cnt_q, blk_cnt_d;
  logic                           blk_phase_q, blk_phase_d;
  logic [NUM_DIGITS-1:0][3:0]     codes_q, codes_d;
  logic [NUM_DIGITS-1:0]          dp_q, dp_d;
  logic [NUM_DIGITS-1:0]          en_q, en_d;
  logic [NUM_DIGITS-1:0]          bmask_q, bmask_d;
  logic [7:0]                     seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0]          seg_en_q, seg_en_d;
  logic                           scan_tick;
  logic                           blanked;

  // Prescaler, digit index and blink timing.
  always_comb begin
    scan_tick   = (pre_q == PreLast);
    pre_d       = scan_tick ? '0 : pre_q + 1'b1;
    idx_d       = idx_q;
    blk_cnt_d   = blk_cnt_q;
    blk_phase_d = blk_phase_q;
    if (scan_tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      if (blk_cnt_q == BlkLast) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  // Shadow registers; holding load high makes them follow the inputs.
  always_comb begin
    codes_d = codes_q;
    dp_d    = dp_q;
    en_d    = en_q;
    bmask_d = bmask_q;
    if (load_i) begin
      codes_d = codes_i;
      dp_d    = dp_mask_i;
      en_d    = digit_en_i;
      bmask_d = blink_mask_i;
    end
  end

  // Output decode from the pre-edge state, so outputs trail state by one cycle.
  always_comb begin
    seg_en_d  = '0;
    seg_out_d = '0;
    blanked   = (pre_q < BlankCyc) || !en_q[idx_q] ||
                (blink_en_i && bmask_q[idx_q] && blk_phase_q);
    if (!blanked) begin
      seg_en_d[idx_q] = 1'b1;
      seg_out_d       = glyph(codes_q[idx_q]) | {7'b0, dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_q       <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b0;
      codes_q     <= {NUM_DIGITS{4'hE}};
      dp_q        <= '0;
      en_q        <= '0;
      bmask_q     <= '0;
      seg_out_q   <= '0;
      seg_en_q    <= '0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_phase_q <= blk_phase_d;
      codes_q     <= codes_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
      bmask_q     <= bmask_d;
      seg_out_q   <= seg_out_d;
      seg_en_q    <= seg_en_d;
    end
  end

  assign seg_out_o  = seg_out_q;
  assign seg_en_o   = seg_en_q;
  assign scan_idx_o = idx_q;

endmodule
